// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control block.
//   FWD_*       : forwarding-select encodings driven on ForwardAE/ForwardBE
//   ALU_CTRL_W  : width of the ALU operation field
//   fwd_sel()   : forwarding priority rule, shared by the A and B operands
package pipe_pkg;

  localparam int ALU_CTRL_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // The M stage holds the younger result, so it wins over W.
  function automatic logic [1:0] fwd_sel(input logic match_m, input logic match_w,
                                         input logic rw_m, input logic rw_w);
    if (match_m && rw_m) return FWD_MEM;
    if (match_w && rw_w) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle of all control/hazard signals exchanged between the datapath and
// the pipeline controller.
//   slave  : controller view (decode bits, condition, branch and register
//            matches in; staged control, forwarding, stall/flush and
//            performance counters out)
//   master : datapath view (the mirror image)
interface pipeline_ctrl_if
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic                  RegWriteD;
  logic                  MemtoRegD;
  logic                  MemWriteD;
  logic                  PCSrcD;
  logic                  ALUSrcD;
  logic [ALU_CTRL_W-1:0] ALUControlD;
  logic                  CondExE;
  logic                  BranchTakenE;
  logic                  Match_1E_M;
  logic                  Match_1E_W;
  logic                  Match_2E_M;
  logic                  Match_2E_W;
  logic                  Match_12D_E;

  logic                  ALUSrcE;
  logic [ALU_CTRL_W-1:0] ALUControlE;
  logic                  MemWriteM;
  logic                  RegWriteW;
  logic                  MemtoRegW;
  logic                  PCSrcW;
  logic [1:0]            ForwardAE;
  logic [1:0]            ForwardBE;
  logic                  StallF;
  logic                  StallD;
  logic                  FlushD;
  logic                  FlushE;
  logic [CNT_W-1:0]      StallCnt;
  logic [CNT_W-1:0]      FlushCnt;

  modport slave (
    input  RegWriteD, MemtoRegD, MemWriteD, PCSrcD, ALUSrcD, ALUControlD,
    input  CondExE, BranchTakenE,
    input  Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
    output ALUSrcE, ALUControlE, MemWriteM, RegWriteW, MemtoRegW, PCSrcW,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
    output StallCnt, FlushCnt
  );

  modport master (
    output RegWriteD, MemtoRegD, MemWriteD, PCSrcD, ALUSrcD, ALUControlD,
    output CondExE, BranchTakenE,
    output Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
    input  ALUSrcE, ALUControlE, MemWriteM, RegWriteW, MemtoRegW, PCSrcW,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
    input  StallCnt, FlushCnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter used for performance debug.
//   clk   : clock
//   reset : asynchronous active-low clear
//   inc   : count one on this edge
//   count : current value; holds at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Control sequencer and hazard unit for the 5-stage core.
// Carries decode control bits through private E/M/W registers (bubbling E
// on FlushE, gating side effects with the execute condition), derives
// operand forwarding from the datapath register matches, produces
// stall/flush controls and counts load-use stalls and taken branches.
//   clk   : core clock
//   reset : asynchronous active-low clear of all state
//   bus   : pipeline_ctrl_if.slave -- decode bits, condition, branch and
//           match inputs; staged controls, forwarding selects,
//           stall/flush controls and performance counters out
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipeline_ctrl_if.slave   bus
);

  logic                  reg_write_e, mem_to_reg_e, mem_write_e, pc_src_e, alu_src_e;
  logic [ALU_CTRL_W-1:0] alu_ctrl_e;
  logic                  reg_write_m, mem_to_reg_m, mem_write_m, pc_src_m;
  logic                  reg_write_w, mem_to_reg_w, pc_src_w;

  logic ldr_stall;
  logic pc_wr_pending;
  logic flush_e;

  // A taken branch kills the dependent wrong-path instruction, so it must
  // not also be stalled behind the load.
  assign ldr_stall     = bus.Match_12D_E & mem_to_reg_e & reg_write_e & ~bus.BranchTakenE;
  assign pc_wr_pending = bus.PCSrcD | pc_src_e | pc_src_m;
  assign flush_e       = ldr_stall | bus.BranchTakenE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_e  <= 1'b0;
      mem_to_reg_e <= 1'b0;
      mem_write_e  <= 1'b0;
      pc_src_e     <= 1'b0;
      alu_src_e    <= 1'b0;
      alu_ctrl_e   <= '0;
      reg_write_m  <= 1'b0;
      mem_to_reg_m <= 1'b0;
      mem_write_m  <= 1'b0;
      pc_src_m     <= 1'b0;
      reg_write_w  <= 1'b0;
      mem_to_reg_w <= 1'b0;
      pc_src_w     <= 1'b0;
    end else begin
      if (flush_e) begin
        reg_write_e  <= 1'b0;
        mem_to_reg_e <= 1'b0;
        mem_write_e  <= 1'b0;
        pc_src_e     <= 1'b0;
        alu_src_e    <= 1'b0;
        alu_ctrl_e   <= '0;
      end else begin
        reg_write_e  <= bus.RegWriteD;
        mem_to_reg_e <= bus.MemtoRegD;
        mem_write_e  <= bus.MemWriteD;
        pc_src_e     <= bus.PCSrcD;
        alu_src_e    <= bus.ALUSrcD;
        alu_ctrl_e   <= bus.ALUControlD;
      end

      // Only architectural side effects are condition-gated; the result
      // select is harmless once RegWrite is dropped.
      reg_write_m  <= reg_write_e & bus.CondExE;
      mem_write_m  <= mem_write_e & bus.CondExE;
      pc_src_m     <= pc_src_e & bus.CondExE;
      mem_to_reg_m <= mem_to_reg_e;

      reg_write_w  <= reg_write_m;
      mem_to_reg_w <= mem_to_reg_m;
      pc_src_w     <= pc_src_m;
    end
  end

  assign bus.ALUSrcE     = alu_src_e;
  assign bus.ALUControlE = alu_ctrl_e;
  assign bus.MemWriteM   = mem_write_m;
  assign bus.RegWriteW   = reg_write_w;
  assign bus.MemtoRegW   = mem_to_reg_w;
  assign bus.PCSrcW      = pc_src_w;

  assign bus.ForwardAE = fwd_sel(bus.Match_1E_M, bus.Match_1E_W, reg_write_m, reg_write_w);
  assign bus.ForwardBE = fwd_sel(bus.Match_2E_M, bus.Match_2E_W, reg_write_m, reg_write_w);

  assign bus.StallF = ldr_stall | pc_wr_pending;
  assign bus.StallD = ldr_stall;
  assign bus.FlushD = pc_wr_pending | pc_src_w | bus.BranchTakenE;
  assign bus.FlushE = flush_e;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ldr_stall),
    .count (bus.StallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.BranchTakenE),
    .count (bus.FlushCnt)
  );

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Control sequencer and hazard unit for the 5-stage pipelined core. It takes decode-stage control bits and carries them through its own E/M/W control registers, applying flushes and condition gating along the way. From the datapath's register-match signals it generates forwarding selects, stalls and flushes. Two saturating counters record load-use stall cycles and taken-branch redirects for performance debug.

Parameters:
CNT_W, 16, width of each saturating performance counter.

Ports:
clk  in  1  core clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset.
RegWriteD  in  1  decode: instruction writes the register file.
MemtoRegD  in  1  decode: result comes from memory (load).
MemWriteD  in  1  decode: store.
PCSrcD  in  1  decode: instruction writes R15 via the writeback path.
ALUSrcD  in  1  decode: ALU B operand is the immediate.
ALUControlD  in  5  decode: ALU operation.
CondExE  in  1  execute-stage condition passed.
BranchTakenE  in  1  execute-stage branch redirect (already condition-qualified).
Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W  in  1 each  source-register match, E against M/W destination.
Match_12D_E  in  1  a decode source equals the E destination.
ALUSrcE  out  1  registered ALUSrcD.
ALUControlE  out  5  registered ALUControlD.
MemWriteM  out  1  store enable to data memory.
RegWriteW  out  1  register-file write enable.
MemtoRegW  out  1  writeback result select.
PCSrcW  out  1  writeback-to-PC select.
ForwardAE, ForwardBE  out  2 each  00 = register file, 01 = ResultW, 10 = ALUOutM.
StallF, StallD, FlushD, FlushE  out  1 each  pipeline register controls.
StallCnt  out  CNT_W  load-use stall cycles.
FlushCnt  out  CNT_W  taken-branch cycles.

Behaviour:
- State registers:
  - E: RegWriteE, MemtoRegE, MemWriteE, PCSrcE, ALUSrcE, ALUControlE.
  - M: RegWriteM, MemtoRegM, MemWriteM, PCSrcM.
  - W: RegWriteW, MemtoRegW, PCSrcW.
  - Counters: StallCnt, FlushCnt.
- Reset: every register clears to 0 asynchronously while reset=0. Release is synchronous to clk.
- E load: on each edge, E registers load the D inputs. If FlushE=1, they load 0 instead (bubble).
- M load: RegWriteM, MemWriteM and PCSrcM load the E bits ANDed with CondExE. MemtoRegM loads MemtoRegE ungated.
- W load: W registers load M registers unconditionally.
- Forwarding (combinational):
  - ForwardAE = 10 if Match_1E_M & RegWriteM.
  - Otherwise ForwardAE = 01 if Match_1E_W & RegWriteW.
  - Otherwise ForwardAE = 00.
  - ForwardBE follows the same rule using the Match_2E_* inputs.
  - M has priority over W.
- Hazards (combinational):
  - LDRstall = Match_12D_E & MemtoRegE & RegWriteE & ~BranchTakenE. A taken branch kills the wrong-path dependent instruction, so it is not stalled.
  - PCWrPending = PCSrcD | PCSrcE | PCSrcM.
  - StallF = LDRstall | PCWrPending.
  - StallD = LDRstall.
  - FlushD = PCWrPending | PCSrcW | BranchTakenE.
  - FlushE = LDRstall | BranchTakenE.
- Latency:
  - A load followed immediately by a dependent instruction costs exactly 1 stall cycle; the bubble enters E.
  - A PC write stalls F for 3 cycles (D, E, M) and flushes D for 4 cycles.
  - A taken branch flushes D and E in the same cycle.
- Counters:
  - StallCnt increments on each edge with StallD=1.
  - FlushCnt increments on each edge with BranchTakenE=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset mid-stall or mid-flush: all state clears immediately. Outputs then follow only the current D inputs, with no residual stall.
- With all inputs 0 after reset, every output is 0.

Decomposition:
- Shared package `pipe_pkg`:
  - Forwarding-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - ALUControl width constant (5).
- One sub-module: `sat_counter` (parameter W; ports clk, reset, inc, count), instantiated twice.

Test Plan:
- Reset: hold reset=0 for 3 cycles with random inputs -> all registered outputs and both counters read 0 during and after reset.
- Forward priority: RegWriteD=1 for two back-to-back instructions, CondExE=1; on cycle 3 assert Match_1E_M=Match_1E_W=1 -> ForwardAE=10. Drop Match_1E_M -> ForwardAE=01. Same check on the B side via Match_2E_*.
- Load-use: load (RegWriteD=1, MemtoRegD=1) enters E, then Match_12D_E=1 -> StallF=StallD=FlushE=1 for exactly 1 cycle; next cycle RegWriteE=0 (bubble); StallCnt=1.
- PC write: PCSrcD=1, RegWriteD=1 for one instruction, CondExE=1 -> StallF high 3 cycles, FlushD high 4 cycles, PCSrcW=1 in cycle 4.
- Condition fail: PCSrcD=RegWriteD=MemWriteD=1 with CondExE=0 in E -> MemWriteM=0, RegWriteW=0, PCSrcW=0; PC-write stall lasts 2 cycles only.
- Branch + load-use collision: BranchTakenE=1 with MemtoRegE=RegWriteE=Match_12D_E=1 -> StallD=0, FlushD=FlushE=1, FlushCnt+1, StallCnt unchanged. Then force 2^16+5 taken cycles -> FlushCnt=16'hFFFF.
